// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the sequential 4x4 multiplier.
package mult_pkg;
  localparam int DW = 2;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;
  localparam logic [1:0] STEP_LL = 2'd0;
  localparam logic [1:0] STEP_LH = 2'd1;
  localparam logic [1:0] STEP_HL = 2'd2;
  localparam logic [1:0] STEP_HH = 2'd3;
  localparam logic [2:0] SH_LL = 3'd0;
  localparam logic [2:0] SH_LH = 3'd2;
  localparam logic [2:0] SH_HL = 3'd2;
  localparam logic [2:0] SH_HH = 3'd4;
endpackage

// File: rtl/mult2_core.sv
// mult2_core: combinational 2x2 unsigned multiplier shared by the sequencer.
module mult2_core (
  input  logic [1:0] A,
  input  logic [1:0] B,
  output logic [3:0] P
);
  assign P = {2'b00, A} * {2'b00, B};
endmodule

// File: rtl/mult4_seq_ctrl.sv
// mult4_seq_ctrl: 4x4 unsigned multiplier walking one 2x2 core over four
// digit products, shift-accumulating into an 8-bit result.
module mult4_seq_ctrl #(
  parameter int DW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] A,
  input  logic [2*DW-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*DW-1:0] P,
  output logic            busy
);
  import mult_pkg::*;
  state_e          state_q, state_d;
  logic [1:0]      step_q, step_d;
  logic [2*DW-1:0] a_q, a_d, b_q, b_d;
  logic [4*DW-1:0] acc_q, acc_d, term;
  logic [DW-1:0]   ca, cb;
  logic [2*DW-1:0] core_p;
  logic [2:0]      sh;
  // step bit 1 picks the high digit of A, bit 0 the high digit of B
  assign ca = step_q[1] ? a_q[2*DW-1:DW] : a_q[DW-1:0];
  assign cb = step_q[0] ? b_q[2*DW-1:DW] : b_q[DW-1:0];
  assign sh = (step_q == STEP_LL) ? SH_LL :
              (step_q == STEP_HH) ? SH_HH :
              (step_q == STEP_LH) ? SH_LH : SH_HL;
  mult2_core u_core (.A(ca), .B(cb), .P(core_p));
  assign term = {{(2*DW){1'b0}}, core_p} << sh;
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        a_d     = A;
        b_d     = B;
        acc_d   = '0;
        step_d  = STEP_LL;
        state_d = MUL;
      end
      MUL: begin
        acc_d   = acc_q + term;
        step_d  = step_q + 2'd1;
        state_d = (step_q == STEP_HH) ? DONE : MUL;
      end
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign P         = acc_q;
endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// tb_mult4_seq_ctrl: randomized and directed checks of mult4_seq_ctrl against
// a transaction-level model (pending product, cycles since acceptance).
module tb_mult4_seq_ctrl;
  logic       clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [3:0] A = 0, B = 0;
  logic       in_ready, out_valid, busy;
  logic [7:0] P;
  int tot = 0, bad = 0;

  mult4_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .P(P), .busy(busy)
  );

  always #5 clk = ~clk;

  logic       pending = 0;
  int         cnt = 0, n_acc = 0, n_drain = 0;
  logic [7:0] exp_p = 0, last_p = 0;
  logic [7:0] got[$];
  logic       rnd_or = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tot++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    tot++;
    bad++;
    $display("FAIL %s timeout t=%0t", nm, $time);
  endtask

  // model: a product becomes visible 4 edges after acceptance, held until taken
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending = 0;
      cnt = 0;
    end else if (pending && cnt >= 4 && out_ready) begin
      pending = 0;
      got.push_back(last_p);
      n_drain++;
    end else if (!pending && in_valid) begin
      pending = 1;
      cnt = 0;
      exp_p = A * B;
      n_acc++;
    end else if (pending && cnt < 4) cnt++;
  end

  always @(negedge clk) begin
    last_p = P;
    if (!rst_n) begin
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_P", int'(P), 0);
    end else begin
      chk("in_ready", int'(in_ready), int'(!pending));
      chk("busy", int'(busy), int'(pending));
      chk("out_valid", int'(out_valid), int'(pending && cnt >= 4));
      if (pending && cnt >= 4) chk("P", int'(P), int'(exp_p));
    end
  end

  always @(negedge clk) if (rnd_or) begin
    #1;
    out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic hold);
    int t = 0;
    @(negedge clk);
    #1;
    A = a;
    B = b;
    in_valid = 1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 200) fail_now("send");
    @(posedge clk);
    if (!hold) begin
      #1;
      in_valid = 0;
    end
  endtask

  task automatic wait_got(input int n);
    int t = 0;
    while (got.size() < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (got.size() < n) fail_now("wait_got");
  endtask

  initial begin
    int lat;
    int base;
    repeat (3) @(negedge clk);
    #1 rst_n = 1;
    // 15 x 15: latency, result and return to IDLE
    send(4'd15, 4'd15, 0);
    chk("model_ee", int'(exp_p), 8'hE1);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    chk("latency", lat, 4);
    chk("P_ee", int'(P), 8'hE1);
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_back", int'(in_ready), 1);
    wait_got(1);
    if (got.size() >= 1) chk("got0", int'(got[0]), 8'hE1);
    // back-to-back with in_valid held
    send(4'd3, 4'd2, 1);
    send(4'd0, 4'd9, 0);
    wait_got(3);
    if (got.size() >= 3) begin
      chk("got1", int'(got[1]), 6);
      chk("got2", int'(got[2]), 0);
    end
    // back-pressure for 20 cycles
    @(negedge clk);
    #1 out_ready = 0;
    send(4'd10, 4'd13, 0);
    repeat (20) @(negedge clk);
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_P", int'(P), 130);
    #1 out_ready = 1;
    wait_got(4);
    if (got.size() >= 4) chk("got3", int'(got[3]), 130);
    // operands wiggle after acceptance
    send(4'd7, 4'd9, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      A = 4'($urandom);
      B = 4'($urandom);
    end
    wait_got(5);
    if (got.size() >= 5) chk("got4", int'(got[4]), 63);
    // reset during step 2
    send(4'd12, 4'd11, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_P", int'(P), 0);
    @(negedge clk);
    #1 rst_n = 1;
    send(4'd5, 4'd5, 0);
    wait_got(6);
    if (got.size() >= 6) chk("got5", int'(got[5]), 25);
    chk("no_extra", got.size(), 6);
    // all 256 pairs with random stalls
    base = got.size();
    rnd_or = 1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ab;
      ab = 8'(i);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(ab[7:4], ab[3:0], 0);
    end
    rnd_or = 0;
    @(negedge clk);
    #1 out_ready = 1;
    wait_got(base + 256);
    chk("exh_count", got.size() - base, 256);
    for (int i = 0; i < 256 && base + i < got.size(); i++)
      chk($sformatf("exh_%0dx%0d", i >> 4, i & 15), int'(got[base + i]), (i >> 4) * (i & 15));
    chk("acc_vs_drain", n_drain, n_acc - 1);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1);
  end
endmodule
